// File: rtl/free_ptr_pool.sv
// Free-pointer pool: circular buffer of unused pointers with a per-pointer allocation map.
// Fills itself with 0..PTR_CNT-1 after reset or flush, then serves allocate/return traffic.
module free_ptr_pool #(
  parameter int A_WIDTH = 8,
  parameter int PTR_CNT = 2**A_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic [A_WIDTH-1:0] add_empty_ptr_i,
  input  logic               add_empty_ptr_en_i,
  input  logic               next_empty_ptr_rd_ack_i,
  output logic [A_WIDTH-1:0] next_empty_ptr_o,
  output logic               next_empty_ptr_val_o,
  output logic               init_done_o,
  output logic [A_WIDTH:0]   free_cnt_o,
  output logic               err_double_free_o,
  output logic               err_range_o,
  output logic               err_underflow_o
);

  localparam logic [A_WIDTH-1:0] LAST  = A_WIDTH'(PTR_CNT - 1);
  localparam logic [A_WIDTH:0]   LIMIT = (A_WIDTH+1)'(PTR_CNT);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t             state, state_nxt;
  logic [A_WIDTH-1:0] mem [PTR_CNT];
  logic [PTR_CNT-1:0] alloc_map, alloc_map_nxt;
  logic [A_WIDTH-1:0] wr_idx, rd_idx, init_k;
  logic [A_WIDTH-1:0] head;
  logic               run, val;
  logic               do_alloc, do_ret, bad_range, bad_double, bad_under;
  logic               mem_we;
  logic [A_WIDTH-1:0] mem_addr, mem_data;

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_INIT;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    if (flush_i)
      state_nxt = S_INIT;
    else if (state == S_INIT && init_k == LAST)
      state_nxt = S_RUN;
  end

  // output logic
  always_comb begin
    run                  = (state == S_RUN);
    val                  = run && (free_cnt_o != '0);
    head                 = mem[rd_idx];
    init_done_o          = run;
    next_empty_ptr_val_o = val;
    next_empty_ptr_o     = head;
  end

  // Map checks use the pre-cycle map, so returning the pointer being allocated
  // this same cycle is a double-free.
  always_comb begin
    bad_range  = run && add_empty_ptr_en_i && ({1'b0, add_empty_ptr_i} >= LIMIT);
    bad_double = run && add_empty_ptr_en_i && !bad_range && !alloc_map[add_empty_ptr_i];
    do_ret     = run && add_empty_ptr_en_i && !bad_range && alloc_map[add_empty_ptr_i];
    do_alloc   = run && next_empty_ptr_rd_ack_i && val;
    bad_under  = run && next_empty_ptr_rd_ack_i && !val;

    alloc_map_nxt = alloc_map;
    if (do_alloc) alloc_map_nxt[head] = 1'b1;
    if (do_ret)   alloc_map_nxt[add_empty_ptr_i] = 1'b0;

    mem_we   = !flush_i && (!run || do_ret);
    mem_addr = run ? wr_idx : init_k;
    mem_data = run ? add_empty_ptr_i : init_k;
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_addr] <= mem_data;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      init_k            <= '0;
      wr_idx            <= '0;
      rd_idx            <= '0;
      free_cnt_o        <= '0;
      alloc_map         <= '0;
      err_double_free_o <= 1'b0;
      err_range_o       <= 1'b0;
      err_underflow_o   <= 1'b0;
    end else if (flush_i) begin
      init_k            <= '0;
      wr_idx            <= '0;
      rd_idx            <= '0;
      free_cnt_o        <= '0;
      alloc_map         <= '0;
      err_double_free_o <= 1'b0;
      err_range_o       <= 1'b0;
      err_underflow_o   <= 1'b0;
    end else begin
      err_double_free_o <= bad_double;
      err_range_o       <= bad_range;
      err_underflow_o   <= bad_under;
      if (!run) begin
        init_k     <= init_k + A_WIDTH'(1);
        free_cnt_o <= free_cnt_o + (A_WIDTH+1)'(1);
      end else begin
        alloc_map  <= alloc_map_nxt;
        free_cnt_o <= free_cnt_o + (A_WIDTH+1)'(do_ret) - (A_WIDTH+1)'(do_alloc);
        if (do_alloc) rd_idx <= (rd_idx == LAST) ? '0 : rd_idx + A_WIDTH'(1);
        if (do_ret)   wr_idx <= (wr_idx == LAST) ? '0 : wr_idx + A_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_free_ptr_pool.sv
// Bench for free_ptr_pool with a non-power-of-two pool (5 pointers, 3-bit width).
// A queue-based pool model is compared every cycle; directed steps add literal checks.
module tb_free_ptr_pool;

  localparam int AW = 3;
  localparam int P  = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [AW-1:0] add_ptr = '0;
  logic          add_en = 1'b0;
  logic          ack = 1'b0;
  logic [AW-1:0] nxt_ptr;
  logic          nxt_val;
  logic          done;
  logic [AW:0]   free_cnt;
  logic          err_df, err_rg, err_un;

  int n_checks = 0;
  int n_fail   = 0;

  free_ptr_pool #(.A_WIDTH(AW), .PTR_CNT(P)) dut (
    .clk_i                   (clk),
    .rst_i                   (rst),
    .flush_i                 (flush),
    .add_empty_ptr_i         (add_ptr),
    .add_empty_ptr_en_i      (add_en),
    .next_empty_ptr_rd_ack_i (ack),
    .next_empty_ptr_o        (nxt_ptr),
    .next_empty_ptr_val_o    (nxt_val),
    .init_done_o             (done),
    .free_cnt_o              (free_cnt),
    .err_double_free_o       (err_df),
    .err_range_o             (err_rg),
    .err_underflow_o         (err_un)
  );

  always #5 clk = ~clk;

  // pool model: a FIFO of free pointers plus an allocated flag per pointer
  int q[$];
  bit amap[8];
  bit m_init = 1'b1;
  int m_k = 0;
  bit m_df = 1'b0, m_rg = 1'b0, m_un = 1'b0;

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < 8; i++) amap[i] = 1'b0;
    m_init = 1'b1;
    m_k = 0;
    m_df = 1'b0; m_rg = 1'b0; m_un = 1'b0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      model_clear();
    end else if (m_init) begin
      q.push_back(m_k);
      m_k++;
      if (m_k == P) m_init = 1'b0;
      m_df = 1'b0; m_rg = 1'b0; m_un = 1'b0;
    end else begin
      bit have, ret_ok;
      int p;
      have   = (q.size() != 0);
      m_un   = ack && !have;
      m_rg   = add_en && (int'(add_ptr) >= P);
      m_df   = add_en && !m_rg && !amap[add_ptr];
      ret_ok = add_en && !m_rg && amap[add_ptr];
      if (ack && have) begin
        p = q.pop_front();
        amap[p] = 1'b1;
      end
      if (ret_ok) begin
        q.push_back(int'(add_ptr));
        amap[add_ptr] = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      bit ev;
      ev = !m_init && (q.size() != 0);
      chk("cmp_done", int'(done), int'(!m_init));
      chk("cmp_val", int'(nxt_val), int'(ev));
      chk("cmp_cnt", int'(free_cnt), q.size());
      chk("cmp_err_df", int'(err_df), int'(m_df));
      chk("cmp_err_rg", int'(err_rg), int'(m_rg));
      chk("cmp_err_un", int'(err_un), int'(m_un));
      if (ev) chk("cmp_ptr", int'(nxt_ptr), q[0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) step();
    chk("rst_done", int'(done), 0);
    chk("rst_val", int'(nxt_val), 0);
    chk("rst_cnt", int'(free_cnt), 0);
    chk("rst_errs", int'({err_df, err_rg, err_un}), 0);

    // init takes exactly P cycles after reset release
    rst = 1'b0;
    repeat (P - 1) step();
    chk("init_not_done", int'(done), 0);
    chk("init_cnt4", int'(free_cnt), 4);
    step();
    chk("init_done", int'(done), 1);
    chk("init_cnt", int'(free_cnt), 5);

    // drain: pointers come out in order 0..4
    ack = 1'b1;
    for (int i = 0; i < P; i++) begin
      chk("drain_ptr", int'(nxt_ptr), i);
      step();
    end
    ack = 1'b0;
    chk("drained_val", int'(nxt_val), 0);
    chk("drained_cnt", int'(free_cnt), 0);

    ack = 1'b1; step(); ack = 1'b0;
    chk("underflow_pulse", int'(err_un), 1);
    step();
    chk("underflow_clear", int'(err_un), 0);

    // return to empty pool shows up next cycle
    add_en = 1'b1; add_ptr = 3'd4; step(); add_en = 1'b0;
    chk("ret_empty_val", int'(nxt_val), 1);
    chk("ret_empty_ptr", int'(nxt_ptr), 4);
    chk("ret_empty_cnt", int'(free_cnt), 1);

    add_en = 1'b1; add_ptr = 3'd6; step(); add_en = 1'b0;
    chk("range_pulse", int'(err_rg), 1);
    chk("range_cnt", int'(free_cnt), 1);

    // double free
    add_en = 1'b1; add_ptr = 3'd2; step();
    chk("ret2_cnt", int'(free_cnt), 2);
    step(); add_en = 1'b0;
    chk("dbl2_pulse", int'(err_df), 1);
    chk("dbl2_cnt", int'(free_cnt), 2);

    // returning the pointer being allocated is a double-free; allocation completes
    ack = 1'b1; add_en = 1'b1; add_ptr = 3'd4; step(); ack = 1'b0; add_en = 1'b0;
    chk("same_df", int'(err_df), 1);
    chk("same_cnt", int'(free_cnt), 1);
    chk("same_head", int'(nxt_ptr), 2);

    // pool at 3, allocate + return together
    add_en = 1'b1; add_ptr = 3'd0; step();
    add_ptr = 3'd1; step(); add_en = 1'b0;
    chk("pre_mix_cnt", int'(free_cnt), 3);
    ack = 1'b1; add_en = 1'b1; add_ptr = 3'd3; step(); add_en = 1'b0;
    chk("mix_cnt", int'(free_cnt), 3);
    chk("mix_ptr0", int'(nxt_ptr), 0);
    step();
    chk("mix_ptr1", int'(nxt_ptr), 1);
    step();
    chk("mix_ptr3", int'(nxt_ptr), 3);
    step(); ack = 1'b0;
    chk("mix_empty", int'(free_cnt), 0);

    // flush in RUN with pointers allocated; same-cycle return ignored
    add_en = 1'b1; add_ptr = 3'd4; step(); add_en = 1'b0;
    flush = 1'b1; add_en = 1'b1; add_ptr = 3'd0; step(); flush = 1'b0; add_en = 1'b0;
    chk("flush_done", int'(done), 0);
    chk("flush_cnt", int'(free_cnt), 0);
    chk("flush_errs", int'({err_df, err_rg, err_un}), 0);
    step(); step();
    flush = 1'b1; step(); flush = 1'b0;
    chk("reflush_cnt", int'(free_cnt), 0);
    repeat (P - 1) step();
    chk("reinit_not_done", int'(done), 0);
    step();
    chk("reinit_done", int'(done), 1);
    chk("reinit_cnt", int'(free_cnt), 5);
    chk("reinit_ptr", int'(nxt_ptr), 0);
    add_en = 1'b1; add_ptr = 3'd3; step(); add_en = 1'b0;
    chk("old_ptr_df", int'(err_df), 1);
    chk("old_ptr_cnt", int'(free_cnt), 5);

    // asynchronous reset mid-operation
    ack = 1'b1; step(); ack = 1'b0;
    chk("pre_rst_cnt", int'(free_cnt), 4);
    #2 rst = 1'b1;
    #1;
    chk("arst_done", int'(done), 0);
    chk("arst_cnt", int'(free_cnt), 0);
    chk("arst_val", int'(nxt_val), 0);
    step();
    rst = 1'b0;
    repeat (P) step();
    chk("post_rst_done", int'(done), 1);
    chk("post_rst_cnt", int'(free_cnt), 5);
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
